// File: rtl/intdiv_pkg.sv
// Shared types for the radix-2 non-restoring divider controller:
// SD2 digit encodings, FSM state enum and the digit-to-operation decoder.
package intdiv_pkg;

   localparam logic [1:0] SD2_NEG1   = 2'b11;
   localparam logic [1:0] SD2_ZERO   = 2'b00;
   localparam logic [1:0] SD2_POS1_1 = 2'b01;
   localparam logic [1:0] SD2_POS1_2 = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ITER,
      S_CONV,
      S_CORR,
      S_DONE
   } state_t;

   typedef struct packed {
      logic add;
      logic sub;
   } sd2_op_t;

   // Both POS1 encodings mean +1, so the redundant code is accepted on decode.
   function automatic sd2_op_t sd2Decode(input logic [1:0] digit);
      sd2_op_t op;
      op.add = (digit == SD2_POS1_1) || (digit == SD2_POS1_2);
      op.sub = (digit == SD2_NEG1);
      return op;
   endfunction

endpackage

// File: rtl/intdiv_ctrl_if.sv
// Handshake, operand, result and digit-trace bundle of the divider controller.
// The slave modport is the divider side; the master modport is the requester.
interface intdiv_ctrl_if #(
   parameter int N = 8
);

   logic          i_start;
   logic [N-1:0]  i_dividend;
   logic [N-1:0]  i_divisor;
   logic          o_ready;
   logic          o_done;
   logic [N-1:0]  o_quotient;
   logic [N-1:0]  o_remainder;
   logic          o_divByZero;
   logic [1:0]    o_digit;
   logic          o_digitValid;

   modport slave (
      input  i_start,
      input  i_dividend,
      input  i_divisor,
      output o_ready,
      output o_done,
      output o_quotient,
      output o_remainder,
      output o_divByZero,
      output o_digit,
      output o_digitValid
   );

   modport master (
      output i_start,
      output i_dividend,
      output i_divisor,
      input  o_ready,
      input  o_done,
      input  o_quotient,
      input  o_remainder,
      input  o_divByZero,
      input  o_digit,
      input  o_digitValid
   );

endinterface

// File: rtl/intdiv_nr_step.sv
// One combinational non-restoring iteration: shifts the partial remainder,
// brings in the next dividend bit and adds or subtracts the divisor.
module intdiv_nr_step
   import intdiv_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N:0]    i_r,
   input  logic          i_qMsb,
   input  logic [N-1:0]  i_d,
   output logic [N:0]    o_rNext,
   output logic [1:0]    o_digit
);

   logic [N:0] w_shifted;
   logic [N:0] w_dExt;

   // R stays within [-D, D), so dropping the old top bit in the shift is
   // harmless: the N+1-bit modular result is the true signed value.
   always_comb begin
      w_shifted = {i_r[N-1:0], i_qMsb};
      w_dExt    = {1'b0, i_d};
      o_rNext   = '0;
      o_digit   = SD2_ZERO;
      if (!i_r[N]) begin
         o_rNext = w_shifted - w_dExt;
         o_digit = SD2_POS1_1;
      end else begin
         o_rNext = w_shifted + w_dExt;
         o_digit = SD2_NEG1;
      end
   end

endmodule

// File: rtl/intdiv_ctrl.sv
// Sequential radix-2 non-restoring divider controller: N SD2 iterations,
// SD2-to-binary conversion, remainder sign correction and a start/done handshake.
module intdiv_ctrl
   import intdiv_pkg::*;
#(
   parameter int N = 8
) (
   input  logic          clk,
   input  logic          rst,
   intdiv_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(N);

   state_t            r_state;
   state_t            w_nextState;

   logic [N-1:0]      r_d;
   logic [N:0]        r_r;
   logic [N-1:0]      r_q;
   logic [N-1:0]      r_qp;
   logic [N-1:0]      r_qn;
   logic [N-1:0]      r_qsd;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_digit;
   logic [N-1:0]      r_quotient;
   logic [N-1:0]      r_remainder;
   logic              r_divByZero;

   logic [N:0]        w_rNext;
   logic [1:0]        w_digit;
   sd2_op_t           w_op;
   logic              w_ready;
   logic              w_done;
   logic              w_digitValid;

   intdiv_nr_step #(.N(N)) u_step (
      .i_r     (r_r),
      .i_qMsb  (r_q[N-1]),
      .i_d     (r_d),
      .o_rNext (w_rNext),
      .o_digit (w_digit)
   );

   assign w_op = sd2Decode(w_digit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState  = r_state;
      w_ready      = 1'b0;
      w_done       = 1'b0;
      w_digitValid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.i_start) begin
               w_nextState = (bus.i_divisor == '0) ? S_DONE : S_ITER;
            end
         end
         S_ITER: begin
            w_digitValid = 1'b1;
            if (r_cnt == '0) begin
               w_nextState = S_CONV;
            end
         end
         S_CONV: w_nextState = S_CORR;
         S_CORR: w_nextState = S_DONE;
         S_DONE: begin
            w_done      = 1'b1;
            w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // Qsd only needs N bits: the corrected quotient is truncated to N bits
   // and the subtraction is exact modulo 2^N.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d         <= '0;
         r_r         <= '0;
         r_q         <= '0;
         r_qp        <= '0;
         r_qn        <= '0;
         r_qsd       <= '0;
         r_cnt       <= '0;
         r_digit     <= SD2_ZERO;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_divByZero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_d <= bus.i_divisor;
                  if (bus.i_divisor == '0) begin
                     r_quotient  <= '1;
                     r_remainder <= bus.i_dividend;
                     r_divByZero <= 1'b1;
                  end else begin
                     r_r   <= '0;
                     r_q   <= bus.i_dividend;
                     r_qp  <= '0;
                     r_qn  <= '0;
                     r_cnt <= CNT_W'(N - 1);
                  end
               end
            end
            S_ITER: begin
               r_r     <= w_rNext;
               r_q     <= {r_q[N-2:0], 1'b0};
               r_qp    <= {r_qp[N-2:0], w_op.add};
               r_qn    <= {r_qn[N-2:0], w_op.sub};
               r_digit <= w_digit;
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_CONV: begin
               r_qsd <= r_qp - r_qn;
            end
            S_CORR: begin
               r_divByZero <= 1'b0;
               if (r_r[N]) begin
                  r_quotient  <= r_qsd - N'(1);
                  r_remainder <= r_r[N-1:0] + r_d;
               end else begin
                  r_quotient  <= r_qsd;
                  r_remainder <= r_r[N-1:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

   // During ITER the trace shows the live digit; afterwards the last one is held.
   assign bus.o_digit      = (r_state == S_ITER) ? w_digit : r_digit;
   assign bus.o_digitValid = w_digitValid;
   assign bus.o_ready      = w_ready;
   assign bus.o_done       = w_done;
   assign bus.o_quotient   = r_quotient;
   assign bus.o_remainder  = r_remainder;
   assign bus.o_divByZero  = r_divByZero;

endmodule

// File: tb/tb_intdiv_ctrl.sv
// Self-checking bench for intdiv_ctrl: directed cases plus back-to-back random
// divisions, with expected results queued at start and compared at done.
module tb_intdiv_ctrl;
   import intdiv_pkg::*;

   localparam int N = 8;

   typedef struct {
      logic [N-1:0] x;
      logic [N-1:0] d;
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   intdiv_ctrl_if #(.N(N)) bus ();

   intdiv_ctrl #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   exp_t monEntry;
   logic lastDone = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkResetValues();
      checkOutput("rstReady", bus.o_ready, 1);
      checkOutput("rstDone", bus.o_done, 0);
      checkOutput("rstQuotient", bus.o_quotient, 0);
      checkOutput("rstRemainder", bus.o_remainder, 0);
      checkOutput("rstDivByZero", bus.o_divByZero, 0);
      checkOutput("rstDigit", bus.o_digit, SD2_ZERO);
      checkOutput("rstDigitValid", bus.o_digitValid, 0);
   endtask

   // Waits for ready at a falling edge, then raises start for one rising edge.
   task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] d);
      exp_t e;
      int   waited = 0;
      @(negedge clk);
      while (!bus.o_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("readyTimeout", waited, waited < 100 ? waited : 0);
      bus.i_start    = 1'b1;
      bus.i_dividend = x;
      bus.i_divisor  = d;
      e.x = x;
      e.d = d;
      if (d == 0) begin
         e.q  = '1;
         e.r  = x;
         e.dz = 1'b1;
      end else begin
         e.q  = x / d;
         e.r  = x % d;
         e.dz = 1'b0;
      end
      sb.push_back(e);
      @(posedge clk);
      #1 bus.i_start = 1'b0;
   endtask

   task automatic runDirected(input logic [N-1:0] x, input logic [N-1:0] d,
                              input int expLat, input int spuriousAt);
      int         cycles     = 0;
      int         validCount = 0;
      logic [1:0] firstDigit = SD2_ZERO;
      logic [1:0] lastDigit  = SD2_ZERO;
      logic       seenDone   = 1'b0;
      applyStimulus(x, d);
      while (!seenDone && cycles < 40) begin
         @(negedge clk);
         cycles++;
         if (bus.o_digitValid) begin
            if (validCount == 0) firstDigit = bus.o_digit;
            lastDigit = bus.o_digit;
            validCount++;
         end
         checkOutput("readyLowBusy", bus.o_ready, 0);
         if (bus.o_done) begin
            seenDone = 1'b1;
            if (d != 0) checkOutput("digitHold", bus.o_digit, lastDigit);
         end
         if (cycles == spuriousAt) begin
            bus.i_start    = 1'b1;
            bus.i_dividend = 8'd10;
            bus.i_divisor  = 8'd0;
         end else begin
            bus.i_start = 1'b0;
         end
      end
      checkOutput("latency", cycles, expLat);
      checkOutput("digitValidCount", validCount, (d == 0) ? 0 : N);
      if (d != 0) checkOutput("firstDigit", firstDigit, SD2_POS1_1);
   endtask

   // Scoreboard monitor: every done pulse pops and checks one expected result.
   always @(negedge clk) begin
      if (rst) begin
         lastDone = 1'b0;
      end else begin
         if (bus.o_done) begin
            checkOutput("doneWidth", lastDone, 0);
            if (sb.size() == 0) begin
               checkOutput("sbUnderflow", sb.size(), 1);
            end else begin
               monEntry = sb.pop_front();
               checkOutput("quotient", bus.o_quotient, monEntry.q);
               checkOutput("remainder", bus.o_remainder, monEntry.r);
               checkOutput("divByZero", bus.o_divByZero, monEntry.dz);
               if (!monEntry.dz) begin
                  checkOutput("invariant",
                              32'(bus.o_quotient) * 32'(monEntry.d) + 32'(bus.o_remainder),
                              32'(monEntry.x));
                  checkOutput("remLtDiv", bus.o_remainder < monEntry.d, 1);
               end
            end
         end
         lastDone = bus.o_done;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, observed hang, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waited;
      int doneSeen;
      logic [N-1:0] rx;
      logic [N-1:0] rd;
      int sel;

      bus.i_start    = 1'b0;
      bus.i_dividend = '0;
      bus.i_divisor  = '0;
      rst            = 1'b1;
      repeat (3) @(negedge clk);
      checkResetValues();
      rst = 1'b0;

      runDirected(8'd100, 8'd7, 11, 0);
      runDirected(8'd255, 8'd1, 11, 0);
      runDirected(8'd0,   8'd5, 11, 0);
      runDirected(8'd6,   8'd7, 11, 0);
      runDirected(8'd13,  8'd0, 1, 0);
      runDirected(8'd200, 8'd3, 11, 3);

      // Abort a division mid-ITER; the queued result must never appear.
      applyStimulus(8'd200, 8'd9);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      sb.delete();
      checkResetValues();
      @(negedge clk);
      rst = 1'b0;
      doneSeen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.o_done) doneSeen++;
      end
      checkOutput("noDoneAfterReset", doneSeen, 0);
      runDirected(8'd50, 8'd8, 11, 0);

      for (int i = 0; i < 3000; i++) begin
         rx  = N'($urandom_range(0, 255));
         sel = $urandom_range(0, 15);
         if (sel == 0)     rd = '0;
         else if (sel < 4) rd = N'($urandom_range(1, 3));
         else              rd = N'($urandom_range(1, 255));
         applyStimulus(rx, rd);
      end

      waited = 0;
      while (sb.size() != 0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("drain", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
